hilo_muldiv: RTL

Execute-stage HI/LO unit: consumes the 8-bit `alucontrol` code produced by the ALU decoder and executes every HI/LO-class operation (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO). It owns the architectural HI/LO registers, runs division as a multi-cycle iterative operation, and stalls the pipeline while a division is in flight. It sits beside the ALU in EX; its `result_e` is muxed into the EX result for MFHI/MFLO.

---
 rtl/hilo_muldiv_pkg.sv | 19 +
 rtl/hilo_muldiv_div_radix2.sv | 68 ++++++
 rtl/hilo_muldiv.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO unit: EX-stage operation codes and sign helpers.
package hilo_muldiv_pkg;

  // HI/LO-class operation codes, same values as the EXE_*_OP codes in defines.vh.
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Two's-complement negate when neg is set; also gives |v| when neg = sign of v.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_radix2.sv
// Unsigned 32/32 restoring divider, one quotient bit per cycle, 32 cycles per divide.
module div_radix2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dsor;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it does not borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, dsor};
    rem_nxt = shifted[31:0];
    quo_nxt = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  // The last step's result is presented combinationally so the caller can write it that same cycle.
  assign done      = busy && (cnt == 6'd31);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  // Operand load on start, then iterate until the 32nd step or an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dsor <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= dividend;
      dsor <= divisor;
    end else if (busy) begin
      if (abort || done) begin
        busy <= 1'b0;
      end else begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage HI/LO unit: MT*/MF*, single-cycle multiply, 32-step division with pipeline stall.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  alucontrol_e,
  input  logic        valid_e,
  input  logic        flush_e,
  input  logic [31:0] srca_e,
  input  logic [31:0] srcb_e,
  output logic        stall_e,
  output logic [31:0] result_e,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic          q_neg;
  logic          r_neg;
  logic          div_zero;
  logic          issue;
  logic          is_div;
  logic          is_sdiv;
  logic          div_start;
  logic          div_abort;
  logic          div_done;
  logic [31:0]   div_q;
  logic [31:0]   div_r;
  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;

  // Reset is folded into issue so a held reset never shows a stall, even with a DIV sitting in EX.
  assign issue     = resetn && (state == IDLE) && valid_e && !flush_e;
  assign is_sdiv   = (alucontrol_e == EXE_DIV_OP);
  assign is_div    = is_sdiv || (alucontrol_e == EXE_DIVU_OP);
  assign div_start = issue && is_div;
  assign div_abort = (state == BUSY) && flush_e;

  assign sa64   = {{32{srca_e[31]}}, srca_e};
  assign sb64   = {{32{srcb_e[31]}}, srcb_e};
  assign prod_s = sa64 * sb64;
  assign prod_u = {32'd0, srca_e} * {32'd0, srcb_e};

  div_radix2 u_div (
    .clk       (clk),
    .rst_n     (resetn),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (neg_if(srca_e, is_sdiv && srca_e[31])),
    .divisor   (neg_if(srcb_e, is_sdiv && srcb_e[31])),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and stall: stall through the issue cycle and every step except the last.
  always_comb begin
    state_nxt = state;
    stall_e   = 1'b0;
    unique case (state)
      IDLE: begin
        if (div_start) begin
          state_nxt = BUSY;
          stall_e   = 1'b1;
        end
      end
      BUSY: begin
        if (flush_e || div_done) state_nxt = IDLE;
        else                     stall_e   = 1'b1;
      end
    endcase
  end

  // Architectural HI/LO plus the sign/zero flags captured at division issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi       <= '0;
      lo       <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (div_start) begin
        q_neg    <= is_sdiv && (srca_e[31] ^ srcb_e[31]);
        r_neg    <= is_sdiv && srca_e[31];
        div_zero <= (srcb_e == 32'd0);
      end
      if ((state == BUSY) && div_done && !flush_e) begin
        if (!div_zero) begin
          lo <= neg_if(div_q, q_neg);
          hi <= neg_if(div_r, r_neg);
        end
      end else if (issue) begin
        case (alucontrol_e)
          EXE_MTHI_OP:  hi       <= srca_e;
          EXE_MTLO_OP:  lo       <= srca_e;
          EXE_MULT_OP:  {hi, lo} <= prod_s;
          EXE_MULTU_OP: {hi, lo} <= prod_u;
          default:      ;
        endcase
      end
    end
  end

  // MFHI/MFLO read the registers directly; writes land at end of EX so no forwarding is needed.
  always_comb begin
    result_e = 32'd0;
    if (alucontrol_e == EXE_MFHI_OP)      result_e = hi;
    else if (alucontrol_e == EXE_MFLO_OP) result_e = lo;
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule
